// File: rtl/me_sad_search_if.sv
// Control and memory-port bundle for me_sad_search: the master side is the estimator,
// the slave side is the environment that starts searches and serves the two memories.
interface me_sad_search_if #(
  parameter int PIX_W  = 8,
  parameter int BLK    = 16,
  parameter int RANGE  = 8,
  parameter int DIST_W = 8
);
  localparam int SW   = BLK + 2 * RANGE;
  localparam int MV_W = $clog2(2 * RANGE);
  localparam int RA_W = $clog2(BLK * BLK);
  localparam int SA_W = $clog2(SW * SW);

  logic              start;
  logic              busy;
  logic              completed;
  logic [DIST_W-1:0] BestDist;
  logic [MV_W-1:0]   motionX;
  logic [MV_W-1:0]   motionY;
  logic [RA_W-1:0]   AddressR;
  logic [PIX_W-1:0]  R;
  logic [SA_W-1:0]   AddressS;
  logic [PIX_W-1:0]  S;

  modport master (
    input  start, R, S,
    output busy, completed, BestDist, motionX, motionY, AddressR, AddressS
  );

  modport slave (
    output start, R, S,
    input  busy, completed, BestDist, motionX, motionY, AddressR, AddressS
  );
endinterface

// File: rtl/me_sad_search.sv
// Full-search block-matching motion estimator: one reference/search pixel pair per cycle,
// SAD per candidate, best vector kept. Optional early termination via `define ME_EARLY_TERM_EN.
module me_sad_search #(
  parameter int PIX_W  = 8,
  parameter int BLK    = 16,
  parameter int RANGE  = 8,
  parameter int DIST_W = 8
) (
  input logic            clk,
  input logic            rst_n,
  me_sad_search_if.master bus
);
  localparam int SW    = BLK + 2 * RANGE;
  localparam int MV_W  = $clog2(2 * RANGE);
  localparam int RA_W  = $clog2(BLK * BLK);
  localparam int SA_W  = $clog2(SW * SW);
  localparam int BW    = $clog2(BLK);
  localparam int ACC_W = PIX_W + 2 * BW;
  localparam int EXT_W = (ACC_W > DIST_W) ? ACC_W : DIST_W;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_CMP, S_DONE} state_e;

  state_e            state_q;
  logic [BW-1:0]     i_q, j_q, i_d, j_d;
  logic [MV_W-1:0]   mx_q, my_q, mx_d, my_d;
  logic [RA_W-1:0]   addr_r_q, addr_r_d;
  logic [SA_W-1:0]   addr_s_q, addr_s_d;
  logic              rd_vld_q, rd_last_q;
  logic [MV_W-1:0]   rd_mx_q, rd_my_q;
  logic [ACC_W-1:0]  acc_q, acc_sum;
  logic              sad_vld_q;
  logic [ACC_W-1:0]  sad_q;
  logic [MV_W-1:0]   sad_mx_q, sad_my_q;
  logic              best_vld_q, best_upd;
  logic [ACC_W-1:0]  best_q, best_d;
  logic [MV_W-1:0]   best_mx_q, best_my_q, best_mx_d, best_my_d;
  logic              busy_q, done_q;
  logic [DIST_W-1:0] dist_q, dist_d;
  logic [MV_W-1:0]   mvx_q, mvy_q;
  logic [PIX_W-1:0]  pix_diff;
  logic [EXT_W-1:0]  best_ext;
  logic              pix_last, cand_last, et_hit;

`ifdef ME_EARLY_TERM_EN
  // Tag of the candidate whose partial sum sits in acc_q; a skip is only legal while
  // that same candidate is still being addressed.
  logic              acc_act_q;
  logic [MV_W-1:0]   acc_mx_q, acc_my_q;
  assign et_hit = (state_q == S_RUN) && best_vld_q && acc_act_q &&
                  (acc_mx_q == mx_q) && (acc_my_q == my_q) && (acc_q >= best_q);
`else
  assign et_hit = 1'b0;
`endif

  // BLK and 2*RANGE are powers of two, so "last index" is simply all ones.
  assign pix_last  = (&i_q) && (&j_q);
  assign cand_last = (&mx_q) && (&my_q);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    j_d  = j_q + 1'b1;
    i_d  = i_q;
    mx_d = mx_q;
    my_d = my_q;
    if (pix_last || et_hit) begin
      j_d  = '0;
      i_d  = '0;
      mx_d = mx_q + 1'b1;
      if (&mx_q) my_d = my_q + 1'b1;
    end else if (&j_q) begin
      i_d = i_q + 1'b1;
    end
    addr_r_d = {i_d, j_d};
    addr_s_d = (SA_W'(my_d) + SA_W'(i_d)) * SA_W'(SW) + SA_W'(mx_d) + SA_W'(j_d);
  end

  always_comb begin
    pix_diff  = (bus.R > bus.S) ? (bus.R - bus.S) : (bus.S - bus.R);
    acc_sum   = acc_q + ACC_W'(pix_diff);
    best_upd  = sad_vld_q && (!best_vld_q || (sad_q < best_q));
    best_d    = best_upd ? sad_q    : best_q;
    best_mx_d = best_upd ? sad_mx_q : best_mx_q;
    best_my_d = best_upd ? sad_my_q : best_my_q;
    best_ext  = EXT_W'(best_d);
    dist_d    = (best_ext > EXT_W'({DIST_W{1'b1}})) ? {DIST_W{1'b1}} : DIST_W'(best_ext);
  end

  // NOTE: all state uses non-blocking assignments; later assignments in the block win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      i_q        <= '0;
      j_q        <= '0;
      mx_q       <= '0;
      my_q       <= '0;
      addr_r_q   <= '0;
      addr_s_q   <= '0;
      rd_vld_q   <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_mx_q    <= '0;
      rd_my_q    <= '0;
      acc_q      <= '0;
      sad_vld_q  <= 1'b0;
      sad_q      <= '0;
      sad_mx_q   <= '0;
      sad_my_q   <= '0;
      best_vld_q <= 1'b0;
      best_q     <= '0;
      best_mx_q  <= '0;
      best_my_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dist_q     <= '0;
      mvx_q      <= '0;
      mvy_q      <= '0;
`ifdef ME_EARLY_TERM_EN
      acc_act_q  <= 1'b0;
      acc_mx_q   <= '0;
      acc_my_q   <= '0;
`endif
    end else begin
      // Accumulate stage: data for the address issued last cycle is on R/S now.
      sad_vld_q <= 1'b0;
      rd_vld_q  <= 1'b0;
      if (rd_vld_q && !et_hit) begin
        if (rd_last_q) begin
          sad_q     <= acc_sum;
          sad_mx_q  <= rd_mx_q;
          sad_my_q  <= rd_my_q;
          sad_vld_q <= 1'b1;
          acc_q     <= '0;
        end else begin
          acc_q     <= acc_sum;
        end
      end
`ifdef ME_EARLY_TERM_EN
      if (rd_vld_q) begin
        acc_act_q <= !rd_last_q && !et_hit;
        acc_mx_q  <= rd_mx_q;
        acc_my_q  <= rd_my_q;
      end
`endif
      if (et_hit) acc_q <= '0;

      // Compare stage: one cycle behind each candidate's last accumulate.
      best_vld_q <= best_vld_q | sad_vld_q;
      best_q     <= best_d;
      best_mx_q  <= best_mx_d;
      best_my_q  <= best_my_d;

      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_q    <= S_RUN;
            i_q        <= '0;
            j_q        <= '0;
            mx_q       <= '0;
            my_q       <= '0;
            addr_r_q   <= '0;
            addr_s_q   <= '0;
            acc_q      <= '0;
            best_vld_q <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
          end
        end
        S_RUN: begin
          if (!et_hit) begin
            rd_vld_q  <= 1'b1;
            rd_last_q <= pix_last;
            rd_mx_q   <= mx_q;
            rd_my_q   <= my_q;
          end
          if ((pix_last || et_hit) && cand_last) begin
            state_q <= S_DRAIN;
          end else begin
            i_q      <= i_d;
            j_q      <= j_d;
            mx_q     <= mx_d;
            my_q     <= my_d;
            addr_r_q <= addr_r_d;
            addr_s_q <= addr_s_d;
          end
        end
        S_DRAIN: state_q <= S_CMP;
        S_CMP: begin
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          dist_q  <= dist_d;
          mvx_q   <= best_mx_d - MV_W'(RANGE);
          mvy_q   <= best_my_d - MV_W'(RANGE);
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.completed = done_q;
  assign bus.BestDist  = dist_q;
  assign bus.motionX   = mvx_q;
  assign bus.motionY   = mvy_q;
  assign bus.AddressR  = addr_r_q;
  assign bus.AddressS  = addr_s_q;
endmodule

// File: doc/me_sad_search.md
# me_sad_search

Parametrised full-search block-matching motion estimator. It is the next-generation core behind the motion-estimation environment. It reads a BLK×BLK reference block and a (BLK+2·RANGE)² search window from two external synchronous memories, one pixel pair per cycle. For each candidate it computes the sum of absolute differences (SAD) and reports the best motion vector and its distance. Block size, search range, pixel width and distance width are generics; the legacy 16×16 / ±8 / 8-bit configuration is the default.

## Interface
- PIX_W, 8, pixel width in bits
- BLK, 16, reference block side in pixels (power of two)
- RANGE, 8, search range: motion components span −RANGE..RANGE−1 (power of two)
- DIST_W, 8, width of reported BestDist (saturating)
- Derived, not overridable: SW = BLK+2·RANGE; MV_W = clog2(2·RANGE); RA_W = clog2(BLK²); SA_W = clog2(SW²); ACC_W = PIX_W+2·clog2(BLK)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request a search; sampled only in IDLE or DONE
- busy  out  1  high while a search is running
- completed  out  1  result valid; held until next accepted start or reset
- BestDist  out  DIST_W  min(best SAD, 2^DIST_W−1)
- motionX, motionY  out  MV_W  best vector, two's complement
- AddressR  out  RA_W  reference memory address, i·BLK+j
- R  in  PIX_W  reference pixel, valid the cycle after AddressR
- AddressS  out  SA_W  search memory address, row·SW+col
- S  in  PIX_W  search pixel, valid the cycle after AddressS

## Operation
- FSM: IDLE → RUN → DRAIN → CMP → DONE. DONE → RUN on start. Any state → IDLE on reset.
- Reset values: busy=0, completed=0, BestDist=0, motionX=0, motionY=0, AddressR=0, AddressS=0.
- Candidate order: my from −RANGE to RANGE−1 (outer), mx from −RANGE to RANGE−1 (inner). Pixels within a candidate are raster ordered: i (row) outer, j inner.
- Addresses for pixel (i,j) of candidate (mx,my):
  - AddressR = i·BLK+j
  - AddressS = (RANGE+my+i)·SW + (RANGE+mx+j)
- Addresses issue every cycle in RUN, back-to-back across candidate boundaries with no bubble.
- Accumulator (ACC_W bits, never overflows) adds |R−S| one cycle after each address.
- At each candidate's last accumulate, the accumulator is compared against best and then cleared for the next candidate.
- Best is initialised by the first candidate. A later candidate replaces it only if its SAD is strictly smaller; ties keep the earlier candidate.
- BestDist saturates; internal best keeps full ACC_W.
- start while busy: ignored, no restart.
- start in DONE: completed drops the next cycle and a new search begins; outputs keep old values until the new result.

## Timing
- C = (2·RANGE)², N = BLK².
- start sampled high at cycle 0; first address at cycle 1; last address at cycle C·N; last accumulate at C·N+1.
- Final compare in CMP at C·N+2. completed, BestDist, motionX and motionY update together at cycle C·N+3. Default config: 65539 cycles.
- busy is high from cycle 1 through C·N+2.
- Memory contract: 1-cycle read latency, no stall.
- Reset mid-search: all outputs return to reset values asynchronously. The next start runs a complete, fresh search.

## Configuration
- ME_EARLY_TERM_EN defined:
  - Once a best exists, if the running accumulator is ≥ best, the remaining pixels of that candidate are skipped.
  - The in-flight read is discarded, and the next candidate's first address issues the cycle after detection.
  - Reported vector and BestDist must be bit-identical to the full search.
  - Latency becomes data-dependent and ≤ C·N+3.
- Not defined: every candidate is fully accumulated, and latency is exactly C·N+3.

## Test plan
- Exact match: random S. R is a copy of the window at mx=3, my=−2 (row 6, col 11). Required: motionX=3, motionY=4'hE, BestDist=0, completed at cycle 65539 (early-term off).
- Tie-break: R and S all zero. Required: motionX=4'h8, motionY=4'h8, BestDist=0.
- Saturation: R all 255, S all 0. SAD is 65280 for every candidate. Required: BestDist=255, motionX=motionY=4'h8.
- Control: start pulsed again at cycle 500 → ignored, completed at 65539. rst_n low at cycle 1000 → all outputs 0 immediately; a subsequent start completes normally.
- Small config: BLK=4, RANGE=2, random memories. Required: result matches the reference model and completed arrives at cycle 16·16+3=259.
- ME_EARLY_TERM_EN: rerun the exact-match case. Required: identical results and completion before cycle 65539.
